// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared UART definitions: transmitter state encoding, timing defaults, latched frame format.
// Pure declarations, so it has no latency and no flow control.
package uart_tx_fifo_drain_pkg;

    localparam int unsigned TICKS_PER_BIT_DEF = 16;
    localparam int unsigned FIFO_LATENCY_DEF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_START  = 3'd4,
        ST_DATA   = 3'd5,
        ST_PARITY = 3'd6,
        ST_STOP   = 3'd7
    } state_e;

    // Odd/even selection is folded into the precomputed parity bit, so it is not kept here.
    typedef struct packed {
        logic bit8;
        logic parity_en;
    } frame_cfg_t;

    function automatic logic [2:0] last_data_bit(input logic bit8);
        return bit8 ? 3'd7 : 3'd6;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_parity_gen.sv
// UART parity bit over 7 or 8 data bits; shared by transmitter and receiver.
// Purely combinational: zero latency and no flow control.
module uart_parity_gen (
    input  logic [7:0] data,
    input  logic       bit8,
    input  logic       odd_n_even,
    output logic       parity
);

    logic [7:0] sent_bits;

    assign sent_bits = bit8 ? data : {1'b0, data[6:0]};
    assign parity    = (^sent_bits) ^ odd_n_even;

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Drains one byte at a time from an external TX FIFO and serialises it as start/data/parity/stop.
// Frame starts FIFO_LATENCY+2 clocks after fifo_empty is seen low in IDLE; one read_n strobe per frame, no prefetch.
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int unsigned TICKS_PER_BIT = TICKS_PER_BIT_DEF,
    parameter int unsigned FIFO_LATENCY  = FIFO_LATENCY_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       read_n,
    output logic       tx,
    output logic       tx_busy,
    output logic       frame_done
);

    localparam int unsigned TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int unsigned WAIT_W = 8;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((FIFO_LATENCY >= 2) ? (FIFO_LATENCY - 2) : 0);

    state_e             state_q,  state_d;
    logic [TICK_W-1:0]  tick_q,   tick_d;
    logic [2:0]         bit_q,    bit_d;
    logic [WAIT_W-1:0]  wait_q,   wait_d;
    logic [7:0]         shift_q,  shift_d;
    frame_cfg_t         cfg_q,    cfg_d;
    logic               parity_q, parity_d;
    logic               tx_q,     tx_d;

    logic               bit_end;
    logic               in_frame;
    logic               load_parity;

    uart_parity_gen u_parity_gen (
        .data       (fifo_data),
        .bit8       (bit8),
        .odd_n_even (odd_n_even),
        .parity     (load_parity)
    );

    assign in_frame = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_PARITY) || (state_q == ST_STOP);
    assign bit_end  = in_frame && baud_tick && (tick_q == TICK_LAST);

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        wait_d   = wait_q;
        shift_d  = shift_q;
        cfg_d    = cfg_q;
        parity_d = parity_q;

        if (in_frame && baud_tick) begin
            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                wait_d  = '0;
                state_d = (FIFO_LATENCY > 1) ? ST_WAIT : ST_LOAD;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_LOAD: begin
                // Frame format is frozen here; later input changes only affect the next byte.
                shift_d         = fifo_data;
                cfg_d.bit8      = bit8;
                cfg_d.parity_en = parity_en;
                parity_d        = load_parity;
                tick_d          = '0;
                bit_d           = '0;
                state_d         = ST_START;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == last_data_bit(cfg_q.bit8)) begin
                        state_d = cfg_q.parity_en ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The line level is decoded from the next state so tx changes exactly with the state register.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            wait_q   <= '0;
            shift_q  <= '0;
            cfg_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            wait_q   <= wait_d;
            shift_q  <= shift_d;
            cfg_q    <= cfg_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign read_n     = (state_q != ST_FETCH);
    assign tx_busy    = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: FIFO model plus a frame-level expected-waveform model.
// Expected tx is derived from the bit list of each frame and the count of baud ticks since START.
module tb_uart_tx_fifo_drain;

    localparam int TPB = 16;
    localparam int FL  = 2;

    logic       clock;
    logic       reset;
    logic       baud_tick;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       read_n;
    logic       tx;
    logic       tx_busy;
    logic       frame_done;

    uart_tx_fifo_drain #(
        .TICKS_PER_BIT (TPB),
        .FIFO_LATENCY  (FL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .read_n     (read_n),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks;
    int failures;
    int cyc;
    int n_reads;
    int n_done;
    int baud_mode;

    logic nxt_reset, nxt_bit8, nxt_par, nxt_odd;

    logic [7:0] fifo_q [$];
    logic [7:0] pend_q [$];
    int         pend_t [$];

    // Frame-level reference: busy window, fetch/start cycles, bit list, ticks seen.
    bit         m_busy;
    int         m_fetch;
    int         m_start;
    int         m_ticks;
    int         m_nbits;
    logic       m_bits [0:11];
    logic [7:0] m_byte;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic build_frame(input logic [7:0] b, input logic b8, input logic pe, input logic odd);
        int   nd;
        logic p;
        nd = b8 ? 8 : 7;
        p  = 1'b0;
        m_bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) begin
            m_bits[1 + i] = b[i];
            p = p ^ b[i];
        end
        m_nbits = 1 + nd;
        if (pe) begin
            m_bits[m_nbits] = p ^ odd;
            m_nbits++;
        end
        m_bits[m_nbits] = 1'b1;
        m_nbits++;
    endtask

    task automatic check_cycle();
        bit   active;
        logic e_tx, e_rn, e_fd;
        active = m_busy && (cyc >= m_start);
        e_rn   = !(m_busy && (cyc == m_fetch));
        e_tx   = active ? m_bits[m_ticks / TPB] : 1'b1;
        e_fd   = active && baud_tick && (m_ticks == m_nbits * TPB - 1);
        check("tx",         32'(tx),         32'(e_tx));
        check("read_n",     32'(read_n),     32'(e_rn));
        check("tx_busy",    32'(tx_busy),    32'(m_busy));
        check("frame_done", 32'(frame_done), 32'(e_fd));

        if (m_busy && cyc == m_fetch && fifo_q.size() != 0) m_byte = fifo_q[0];
        if (m_busy && cyc == m_start - 1) build_frame(m_byte, bit8, parity_en, odd_n_even);

        if (reset) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (active && baud_tick) begin
                m_ticks++;
                if (m_ticks == m_nbits * TPB) m_busy = 1'b0;
            end
        end else if (!fifo_empty) begin
            m_busy  = 1'b1;
            m_fetch = cyc + 1;
            m_start = cyc + FL + 2;
            m_ticks = 0;
        end

        if (read_n === 1'b0) begin
            n_reads++;
            if (fifo_q.size() != 0) begin
                pend_q.push_back(fifo_q.pop_front());
                pend_t.push_back(cyc + FL);
            end
        end
        if (frame_done === 1'b1) n_done++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        reset      = nxt_reset;
        bit8       = nxt_bit8;
        parity_en  = nxt_par;
        odd_n_even = nxt_odd;
        fifo_empty = (fifo_q.size() == 0);
        case (baud_mode)
            0:       baud_tick = 1'b1;
            1:       baud_tick = (cyc % 5 == 0);
            default: baud_tick = ($urandom_range(0, 3) == 0);
        endcase
        if (pend_t.size() != 0 && pend_t[0] == cyc) begin
            fifo_data = pend_q.pop_front();
            void'(pend_t.pop_front());
        end
        @(negedge clock);
        check_cycle();
    endtask

    task automatic run_to_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((m_busy || fifo_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
        repeat (3) step();
    endtask

    task automatic wait_ticks(input string tag, input int ticks);
        int n;
        n = 0;
        while (!(m_busy && cyc >= m_start && m_ticks >= ticks) && n < 2000) begin
            step();
            n++;
        end
        check(tag, 32'(n < 2000), 32'd1);
    endtask

    initial begin
        int r0, d0, nbytes;
        checks = 0; failures = 0; cyc = 0; n_reads = 0; n_done = 0;
        baud_mode = 0;
        m_busy = 1'b0; m_fetch = -1; m_start = -1; m_ticks = 0; m_nbits = 2; m_byte = 8'h00;
        for (int i = 0; i < 12; i++) m_bits[i] = 1'b1;
        reset = 1'b1; baud_tick = 1'b0; bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        fifo_empty = 1'b1; fifo_data = 8'h00;
        nxt_reset = 1'b1; nxt_bit8 = 1'b1; nxt_par = 1'b0; nxt_odd = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_read_n", 32'(read_n), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        nxt_reset = 1'b0;
        step();

        // 0x55, 8N1, baud every clock
        r0 = n_reads; d0 = n_done;
        fifo_q.push_back(8'h55);
        run_to_idle("t55_budget", 400);
        check("t55_reads", 32'(n_reads - r0), 32'd1);
        check("t55_done", 32'(n_done - d0), 32'd1);

        // 0xA3, 7 data bits, even parity
        nxt_bit8 = 1'b0; nxt_par = 1'b1; nxt_odd = 1'b0;
        r0 = n_reads; d0 = n_done;
        fifo_q.push_back(8'hA3);
        run_to_idle("t7e_budget", 400);
        check("t7e_done", 32'(n_done - d0), 32'd1);

        // 0xA3, 8 data bits, odd parity, format inputs scrambled mid-frame
        nxt_bit8 = 1'b1; nxt_par = 1'b1; nxt_odd = 1'b1;
        d0 = n_done;
        fifo_q.push_back(8'hA3);
        wait_ticks("t8o_reach", 40);
        nxt_odd = 1'b0; nxt_bit8 = 1'b0; nxt_par = 1'b0;
        run_to_idle("t8o_budget", 400);
        check("t8o_done", 32'(n_done - d0), 32'd1);

        // Three preloaded bytes
        nxt_bit8 = 1'b1; nxt_par = 1'b1; nxt_odd = 1'b0;
        r0 = n_reads; d0 = n_done;
        fifo_q.push_back(8'h12); fifo_q.push_back(8'h34); fifo_q.push_back(8'hC5);
        run_to_idle("t3b_budget", 1000);
        check("t3b_reads", 32'(n_reads - r0), 32'd3);
        check("t3b_done", 32'(n_done - d0), 32'd3);

        // Reset during third data bit
        nxt_par = 1'b0;
        d0 = n_done;
        fifo_q.push_back(8'h5A);
        wait_ticks("trst_reach", 3 * TPB + 4);
        nxt_reset = 1'b1;
        step();
        nxt_reset = 1'b0;
        step();
        check("trst_tx", 32'(tx), 32'd1);
        check("trst_busy", 32'(tx_busy), 32'd0);
        r0 = n_reads;
        repeat (20) step();
        check("trst_noread", 32'(n_reads - r0), 32'd0);
        check("trst_nodone", 32'(n_done - d0), 32'd0);
        fifo_q.push_back(8'h3C);
        run_to_idle("trst_next", 400);
        check("trst_next_done", 32'(n_done - d0), 32'd1);

        // Sparse baud ticks with an empty FIFO: line must stay idle
        baud_mode = 1;
        r0 = n_reads; d0 = n_done;
        repeat (200) step();
        check("tidle_reads", 32'(n_reads - r0), 32'd0);
        check("tidle_done", 32'(n_done - d0), 32'd0);

        // Randomised bytes, formats, tick density and mid-frame format changes
        baud_mode = 2;
        for (int it = 0; it < 12; it++) begin
            nxt_bit8 = 1'($urandom); nxt_par = 1'($urandom); nxt_odd = 1'($urandom);
            nbytes = $urandom_range(1, 2);
            r0 = n_reads; d0 = n_done;
            for (int b = 0; b < nbytes; b++) fifo_q.push_back(8'($urandom));
            repeat ($urandom_range(0, 300)) step();
            nxt_bit8 = 1'($urandom); nxt_par = 1'($urandom); nxt_odd = 1'($urandom);
            run_to_idle("trand_budget", 4000);
            check("trand_reads", 32'(n_reads - r0), 32'(nbytes));
            check("trand_done", 32'(n_done - d0), 32'(nbytes));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
